spu_fetch_queue: RTL and testbench
==================================

# spu_fetch_queue

Instruction fetch front end that feeds the SPU decode/control stage. Generates aligned pair fetches into instruction local store, buffers returned 64-bit instruction pairs in a small FIFO, and presents one pair per cycle to decode under a valid/ready handshake. Handles branch redirect (flush plus restart at target) and decode-driven fetch stall.

## Interface
- PC_W, default 32: byte-address width of the fetch PC.
- DEPTH, default 4: queue entries (instruction pairs); power of two, ≥2.
- RESET_PC, default 0: first fetch address after reset; 8-byte aligned.

- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- fetch_en  in  1  high permits new fetch requests.
- redirect_valid  in  1  branch taken; flush and restart.
- redirect_pc  in  PC_W  redirect target, 4-byte aligned.
- imem_req  out  1  fetch request, address on imem_addr.
- imem_addr  out  PC_W  pair address, bits [2:0] always 0.
- imem_rvalid  in  1  response valid, exactly 1 cycle after imem_req.
- imem_rdata  in  64  pair; [63:32] = word at addr, [31:0] = word at addr+4.
- out_valid  out  1  pair available to decode.
- out_ready  in  1  decode accepts pair.
- out_pc  out  PC_W  address of pair (8-aligned).
- instruction1  out  32  slot 0 word.
- instruction2  out  32  slot 1 word.
- out_slot_valid  out  2  bit0 = slot 0 valid, bit1 = slot 1 valid.

## Operation
- States: IDLE, FETCH, FLUSH.
- IDLE: entered on reset. On the first cycle with reset high, go to FETCH with fetch_pc = RESET_PC.
- FETCH: imem_req = fetch_en && (count + inflight < DEPTH). Each issued request sets inflight for one cycle and advances fetch_pc by 8.
- FLUSH: one cycle. Entered when redirect_valid is high in any state. No request is issued. Next state is FETCH, with fetch_pc = {redirect_pc[PC_W-1:3], 3'b000}.
- Epoch bit toggles on every redirect. Each request carries the current epoch. A response whose epoch differs from the current epoch is dropped.
- Push on imem_rvalid with matching epoch. Entry stores pc, rdata and slot_valid.
  - slot_valid = 2'b10 for the first pair after a redirect with redirect_pc[2] = 1.
  - slot_valid = 2'b11 otherwise.
- Pop when out_valid && out_ready. The head entry drives out_pc, instruction1, instruction2 and out_slot_valid.
- Redirect clears the queue (count = 0) at the end of the redirect cycle. A pop accepted in that same cycle still counts as consumed by decode.
- Redirect has priority over push and over request issue.
- fetch_en low blocks new requests only. An in-flight response still pushes, and decode may keep draining.
- count never exceeds DEPTH; the credit rule guarantees this. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.

## Timing
- While reset is low, all outputs are 0: imem_req, imem_addr, out_valid, out_pc, instruction1, instruction2, out_slot_valid.
- Reset release latency, with cycle 1 = first cycle reset is high:
  - cycle 1: IDLE.
  - cycle 2: imem_req with addr RESET_PC.
  - cycle 3: rvalid arrives.
  - cycle 4: out_valid.
- Steady state: one request per cycle, one pair per cycle; fetch-to-out_valid latency is 2 cycles.
- Redirect at cycle R:
  - out_valid = 0 in R+1.
  - FLUSH in R+1.
  - Request to the target in R+2.
  - Target pair out_valid in R+4.
  - rvalid in R+1 (old stream) is discarded.
- Redirect during FLUSH: restart uses the newest redirect_pc and FLUSH extends one cycle.
- Outputs hold stable while out_valid && !out_ready.

## Structure
- Package spu_fetch_pkg holds:
  - PC_W default and INSN_W = 32.
  - fetch_entry_t struct: pc, insn0, insn1, slot_valid.
  - fetch_state_t enum: IDLE, FETCH, FLUSH.
- Sub-module spu_fetch_fifo: generic synchronous FIFO of fetch_entry_t with DEPTH, push, pop, clear, count, and head output. The top level holds the FSM, PC, epoch and credit logic.

## Test plan
- Reset release, RESET_PC = 0, out_ready = 1 → requests at 0x0, 0x8, 0x10…; first out_valid 3 cycles after reset rises; instruction1/instruction2 = rdata[63:32]/[31:0].
- out_ready = 0, DEPTH = 4 → exactly 4 requests, then imem_req = 0; raising out_ready resumes one request per pop; no pair is lost or duplicated.
- redirect_valid with redirect_pc = 0x104 while the queue is full and a response is in flight → queue empty next cycle, in-flight data dropped, next request addr 0x100, first output out_slot_valid = 2'b10, out_pc = 0x100.
- Redirect on two consecutive cycles (targets 0x200, then 0x300) → only 0x300 is fetched; no 0x200 data reaches the output.
- fetch_en low for 5 cycles mid-stream → no requests; the in-flight pair is still delivered; fetch resumes at the next sequential address.
- reset asserted low mid-stream with the queue half full → all outputs 0 immediately; after release, fetch restarts at RESET_PC with an empty queue.

Source files
------------

// File: rtl/spu_fetch_pkg.sv
// spu_fetch_pkg: shared types and constants for the SPU instruction fetch front end.
package spu_fetch_pkg;
  localparam int PC_W = 32;
  localparam int INSN_W = 32;
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn0;
    logic [INSN_W-1:0] insn1;
    logic [1:0]        slot_valid;
  } fetch_entry_t;
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} fetch_state_t;
endpackage

// File: rtl/spu_fetch_fifo.sv
// spu_fetch_fifo: synchronous FIFO of fetched instruction pairs with clear and head peek.
module spu_fetch_fifo
  import spu_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop && count_q != '0;
    do_push = push && count_q != FULL;
    rd_d = clear ? '0 : rd_q + AW'(do_pop);
    wr_d = clear ? '0 : wr_q + AW'(do_push);
    count_d = clear ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
    end
  end
  // Storage needs no reset: the top masks the head while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_q] <= din;
  end
  assign head = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/spu_fetch_queue.sv
// spu_fetch_queue: SPU fetch front end issuing aligned pair fetches into a small
// queue, with epoch-tagged redirect flush and credit-limited request issue.
module spu_fetch_queue #(
  parameter int PC_W = spu_fetch_pkg::PC_W,
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [63:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     instruction1,
  output logic [31:0]     instruction2,
  output logic [1:0]      out_slot_valid
);
  import spu_fetch_pkg::*;
  localparam int EW = spu_fetch_pkg::PC_W;
  fetch_state_t state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic epoch_q, epoch_d, half_q, half_d;
  logic inflight_q, inflight_d, req_epoch_q, req_epoch_d, req_half_q, req_half_d;
  logic push;
  logic unused_pc_bits;
  fetch_entry_t din, head;
  logic [$clog2(DEPTH):0] count;
  assign unused_pc_bits = ^redirect_pc[1:0];
  always_comb begin
    imem_req = state_q == FETCH && fetch_en && !redirect_valid && int'(count) + int'(inflight_q) < DEPTH;
    state_d = redirect_valid ? FLUSH : FETCH;
    fetch_pc_d = redirect_valid ? {redirect_pc[PC_W-1:3], 3'b000} :
                 state_q == IDLE ? RESET_PC :
                 imem_req ? fetch_pc_q + PC_W'(8) : fetch_pc_q;
    epoch_d = epoch_q ^ redirect_valid;
    // half_q marks that the next issued pair starts mid-pair at a redirect target
    half_d = redirect_valid ? redirect_pc[2] : imem_req ? 1'b0 : half_q;
    inflight_d = imem_req;
    req_pc_d = fetch_pc_q;
    req_epoch_d = epoch_q;
    req_half_d = half_q;
    push = imem_rvalid && inflight_q && req_epoch_q == epoch_q;
    din = '{pc: EW'(req_pc_q), insn0: imem_rdata[63:32], insn1: imem_rdata[31:0],
            slot_valid: req_half_q ? 2'b10 : 2'b11};
    imem_addr = imem_req ? fetch_pc_q : '0;
    out_valid = count != '0;
    out_pc = out_valid ? PC_W'(head.pc) : '0;
    instruction1 = out_valid ? head.insn0 : '0;
    instruction2 = out_valid ? head.insn1 : '0;
    out_slot_valid = out_valid ? head.slot_valid : 2'b00;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      epoch_q <= 1'b0;
      half_q <= 1'b0;
      inflight_q <= 1'b0;
      req_pc_q <= '0;
      req_epoch_q <= 1'b0;
      req_half_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      epoch_q <= epoch_d;
      half_q <= half_d;
      inflight_q <= inflight_d;
      req_pc_q <= req_pc_d;
      req_epoch_q <= req_epoch_d;
      req_half_q <= req_half_d;
    end
  end
  spu_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(out_valid && out_ready),
    .clear(redirect_valid),
    .din(din),
    .head(head),
    .count(count)
  );
endmodule

// File: tb/tb_spu_fetch_queue.sv
// tb_spu_fetch_queue: directed and randomized checks of the fetch queue against an
// instruction-stream reference model and a one-cycle-latency memory responder.
module tb_spu_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clk = 1'b0, reset = 1'b0, fetch_en = 1'b0, redirect_valid = 1'b0;
  logic imem_rvalid = 1'b0, out_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [63:0] imem_rdata = '0;
  logic imem_req, out_valid;
  logic [31:0] imem_addr, out_pc, instruction1, instruction2;
  logic [1:0] out_slot_valid;
  int passes = 0, total = 0, reqs = 0, pops = 0, p0 = 0;
  logic pend = 1'b0;
  logic [31:0] pend_addr = '0, exp_pc = RESET_PC, prev_pc = '0, last_req = '0, saved = '0;
  logic exp_half = 1'b0, prev_redir = 1'b0, prev_stall = 1'b0;
  logic s_req, s_ov;
  logic [31:0] s_addr, s_pc;
  logic [1:0] s_slot;

  always #5 clk = ~clk;

  spu_fetch_queue #(.PC_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .instruction1(instruction1), .instruction2(instruction2),
    .out_slot_valid(out_slot_valid)
  );

  function automatic logic [63:0] mem(input logic [31:0] a);
    return {a ^ 32'h5EED_0000, ~a + 32'h0000_0101};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"}, 64'(imem_req), 64'h0);
    check({tag, "_addr"}, 64'(imem_addr), 64'h0);
    check({tag, "_ov"}, 64'(out_valid), 64'h0);
    check({tag, "_pc"}, 64'(out_pc), 64'h0);
    check({tag, "_i1"}, 64'(instruction1), 64'h0);
    check({tag, "_i2"}, 64'(instruction2), 64'h0);
    check({tag, "_slot"}, 64'(out_slot_valid), 64'h0);
  endtask

  // One clock cycle: memory answers last cycle's request, outputs are observed
  // mid-cycle and the expected instruction stream is advanced.
  task automatic tick();
    logic [63:0] d;
    imem_rvalid = pend && reset;
    imem_rdata = pend ? mem(pend_addr) : '0;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_ov = out_valid; s_pc = out_pc; s_slot = out_slot_valid;
    if (reset) begin
      pend = imem_req;
      pend_addr = imem_addr;
      if (imem_req) begin
        reqs++;
        last_req = imem_addr;
        check("addr_align", 64'(imem_addr[2:0]), 64'h0);
      end
      if (prev_redir) begin
        check("flush_no_valid", 64'(out_valid), 64'h0);
        check("flush_no_req", 64'(imem_req), 64'h0);
      end
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'h1);
        check("hold_pc", 64'(out_pc), 64'(prev_pc));
      end
      if (out_valid && out_ready) begin
        d = mem(exp_pc);
        check("pop_pc", 64'(out_pc), 64'(exp_pc));
        check("pop_i1", 64'(instruction1), 64'(d[63:32]));
        check("pop_i2", 64'(instruction2), 64'(d[31:0]));
        check("pop_slot", 64'(out_slot_valid), exp_half ? 64'h2 : 64'h3);
        exp_pc = exp_pc + 32'd8;
        exp_half = 1'b0;
        pops++;
      end
      if (redirect_valid) begin
        exp_pc = {redirect_pc[31:3], 3'b000};
        exp_half = redirect_pc[2];
      end
      prev_redir = redirect_valid;
      prev_stall = out_valid && !out_ready && !redirect_valid;
      prev_pc = out_pc;
    end else begin
      pend = 1'b0;
      prev_redir = 1'b0;
      prev_stall = 1'b0;
      exp_pc = RESET_PC;
      exp_half = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    fetch_en = 1'b1; out_ready = 1'b1;
    #1;
    check_zero("rst");
    repeat (2) tick();
    reset = 1'b1;
    tick(); check("c1_req", 64'(s_req), 64'h0);
    tick(); check("c2_req", 64'(s_req), 64'h1); check("c2_addr", 64'(s_addr), 64'(RESET_PC));
    tick(); check("c3_ov", 64'(s_ov), 64'h0); check("c3_addr", 64'(s_addr), 64'(RESET_PC + 32'd8));
    tick(); check("c4_ov", 64'(s_ov), 64'h1); check("c4_pc", 64'(s_pc), 64'(RESET_PC));
    repeat (4) tick();
    // backpressure: credits stop issue at DEPTH
    redirect_valid = 1'b1; redirect_pc = 32'h1000; out_ready = 1'b0; tick(); redirect_valid = 1'b0;
    reqs = 0;
    repeat (12) tick();
    check("bp_reqs", 64'(reqs), 64'(DEPTH));
    check("bp_stopped", 64'(s_req), 64'h0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    tick(); check("resume_req", 64'(s_req), 64'h1); check("resume_addr", 64'(s_addr), 64'h1020);
    // redirect to a mid-pair target while full with a response in flight
    redirect_valid = 1'b1; redirect_pc = 32'h104; tick(); redirect_valid = 1'b0;
    tick(); check("rd_empty", 64'(s_ov), 64'h0); check("rd_flush", 64'(s_req), 64'h0);
    out_ready = 1'b1;
    tick(); check("rd_req", 64'(s_req), 64'h1); check("rd_addr", 64'(s_addr), 64'h100);
    tick(); check("rd_ov_lat", 64'(s_ov), 64'h0);
    tick(); check("rd_ov", 64'(s_ov), 64'h1); check("rd_pc", 64'(s_pc), 64'h100); check("rd_slot", 64'(s_slot), 64'h2);
    tick(); check("rd_pc2", 64'(s_pc), 64'h108); check("rd_slot2", 64'(s_slot), 64'h3);
    repeat (3) tick();
    // back-to-back redirects: only the newest target is fetched
    redirect_valid = 1'b1; redirect_pc = 32'h200; tick();
    redirect_pc = 32'h300; tick(); redirect_valid = 1'b0;
    tick(); check("dr_flush", 64'(s_req), 64'h0);
    tick(); check("dr_req", 64'(s_req), 64'h1); check("dr_addr", 64'(s_addr), 64'h300);
    repeat (4) tick();
    // fetch_en low: no issue, in-flight pair still drains
    fetch_en = 1'b0; reqs = 0; p0 = pops;
    repeat (5) tick();
    check("fe_noreq", 64'(reqs), 64'h0);
    check("fe_drain", 64'(pops > p0), 64'h1);
    saved = last_req;
    fetch_en = 1'b1;
    tick(); check("fe_resume", 64'(s_req), 64'h1); check("fe_addr", 64'(s_addr), 64'(saved + 32'd8));
    // asynchronous reset mid-stream with a partly full queue
    out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check_zero("mid_rst");
    repeat (2) tick();
    reset = 1'b1; out_ready = 1'b1;
    tick(); check("rr_c1_req", 64'(s_req), 64'h0);
    tick(); check("rr_c2_req", 64'(s_req), 64'h1); check("rr_c2_addr", 64'(s_addr), 64'(RESET_PC));
    tick(); check("rr_empty", 64'(s_ov), 64'h0);
    // randomized traffic against the stream model
    for (int i = 0; i < 400; i++) begin
      fetch_en = $urandom_range(0, 9) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      redirect_valid = $urandom_range(0, 19) == 0;
      redirect_pc = {16'h0, 14'($urandom), 2'b00};
      tick();
    end
    redirect_valid = 1'b0; fetch_en = 1'b1; out_ready = 1'b1; p0 = pops;
    repeat (10) tick();
    check("drain_live", 64'(pops - p0 >= 5), 64'h1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
